// File: rtl/decode_scan.sv
// Registered AW-to-2**AW one-hot decoder with a scan sequencer that walks the select bit from A to Last.
// Latency 1 clock in direct mode; Enable=0 blanks O and freezes a scan in place (no other backpressure).
module decode_scan #(
    parameter int AW          = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [AW-1:0]       i_a,
    input  logic                i_enable,
    input  logic                i_mode,
    input  logic                i_start,
    input  logic [AW-1:0]       i_last,
    output logic [(1<<AW)-1:0]  o_o,
    output logic [AW-1:0]       o_index,
    output logic                o_busy,
    output logic                o_done
);
    localparam int N  = 1 << AW;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_o;
    logic [AW-1:0] r_index;
    logic [AW-1:0] r_last;
    logic [HW-1:0] r_hold;
    logic          r_busy;
    logic          r_done;

    logic          w_start_ok;
    logic          w_hold_end;
    logic [AW-1:0] w_index_next;

    function automatic logic [N-1:0] onehot(input logic [AW-1:0] addr);
        logic [N-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

    assign w_start_ok   = i_mode & i_start & i_enable;
    assign w_hold_end   = (r_hold == HOLD_LAST);
    assign w_index_next = r_index + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_o     <= '0;
            r_index <= '0;
            r_last  <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start_ok) begin
                        r_index <= i_a;
                        r_last  <= i_last;
                        r_hold  <= '0;
                        r_o     <= onehot(i_a);
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end else if (!i_mode && i_enable) begin
                        r_o <= onehot(i_a);
                    end else begin
                        r_o <= '0;
                    end
                end
                S_SCAN: begin
                    // A paused scan keeps index and hold count, so it resumes mid-hold.
                    if (!i_enable) begin
                        r_o <= '0;
                    end else if (!w_hold_end) begin
                        r_hold <= r_hold + 1'b1;
                        r_o    <= onehot(r_index);
                    end else if (r_index == r_last) begin
                        r_o     <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_index <= w_index_next;
                        r_hold  <= '0;
                        r_o     <= onehot(w_index_next);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_o     <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_o     <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_o     = r_o;
    assign o_index = r_index;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
endmodule

// File: tb/tb_decode_scan.sv
// Bench for decode_scan: two instances (hold 2 and hold 1) share stimulus; expectations queued per cycle.
module tb_decode_scan;
    typedef struct packed {
        logic [15:0] o;
        logic        busy;
        logic        done;
        logic [3:0]  idx;
        logic        chk_idx;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a;
    logic        en;
    logic        mode;
    logic        start;
    logic [3:0]  last;
    logic [15:0] o1, o2;
    logic [3:0]  idx1, idx2;
    logic        busy1, busy2, done1, done2;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    decode_scan #(.AW(4), .HOLD_CYCLES(2)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_enable(en), .i_mode(mode),
        .i_start(start), .i_last(last), .o_o(o1), .o_index(idx1), .o_busy(busy1), .o_done(done1)
    );

    decode_scan #(.AW(4), .HOLD_CYCLES(1)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_enable(en), .i_mode(mode),
        .i_start(start), .i_last(last), .o_o(o2), .o_index(idx2), .o_busy(busy2), .o_done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] o, input logic b, input logic d, input logic [3:0] i, input logic ci);
        exp_t e;
        e.o = o; e.busy = b; e.done = d; e.idx = i; e.chk_idx = ci;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int n);
        start = 1'b0; mode = 1'b1; en = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; a = '0; en = 1'b0; mode = 1'b0; start = 1'b0; last = '0;
        #3;
        push(16'h0000, 1'b0, 1'b0, 4'd0, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if (o1 !== e.o || busy1 !== e.busy || done1 !== e.done || idx1 !== e.idx) begin
            miscompares++;
            $display("FAIL reset_dut1 o=%h busy=%b done=%b idx=%0d expected all zero", o1, busy1, done1, idx1);
        end
        push(16'h0000, 1'b0, 1'b0, 4'd0, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if (o2 !== e.o || busy2 !== e.busy || done2 !== e.done || idx2 !== e.idx) begin
            miscompares++;
            $display("FAIL reset_dut2 o=%h busy=%b done=%b idx=%0d expected all zero", o2, busy2, done2, idx2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_direct();
        exp_t e;
        mode = 1'b0; en = 1'b1; start = 1'b0;
        for (int k = 0; k < 33; k++) begin
            if (k < 32) a = 4'(k / 2);
            else en = 1'b0;
            push((k < 32) ? (16'h0001 << (k / 2)) : 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (o1 !== e.o || busy1 !== e.busy || done1 !== e.done) begin
                miscompares++;
                $display("FAIL direct k=%0d o=%h busy=%b done=%b expected o=%h busy=%b done=%b",
                         k, o1, busy1, done1, e.o, e.busy, e.done);
            end
        end
    endtask

    // Start pulse at k=0; a second Start and changed A/Last at k=3 must be ignored.
    task automatic test_scan();
        exp_t e;
        mode = 1'b1; en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            start = (k == 0) || (k == 3);
            a     = (k == 0) ? 4'd3 : 4'd7;
            last  = (k == 0) ? 4'd6 : 4'd2;
            if (k < 8)       push(16'h0001 << (3 + k / 2), 1'b1, 1'b0, 4'(3 + k / 2), 1'b1);
            else if (k == 8) push(16'h0000, 1'b0, 1'b1, 4'd0, 1'b0);
            else             push(16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (o1 !== e.o || busy1 !== e.busy || done1 !== e.done || (e.chk_idx && idx1 !== e.idx)) begin
                miscompares++;
                $display("FAIL scan k=%0d o=%h busy=%b done=%b idx=%0d expected o=%h busy=%b done=%b idx=%0d",
                         k, o1, busy1, done1, idx1, e.o, e.busy, e.done, e.idx);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [3:0] ix;
        mode = 1'b1; en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            start = (k == 0);
            a = 4'd14; last = 4'd1;
            ix = 4'(14 + k);
            if (k < 4)       push(16'h0001 << ix, 1'b1, 1'b0, ix, 1'b1);
            else if (k == 4) push(16'h0000, 1'b0, 1'b1, 4'd0, 1'b0);
            else             push(16'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (o2 !== e.o || busy2 !== e.busy || done2 !== e.done || (e.chk_idx && idx2 !== e.idx)) begin
                miscompares++;
                $display("FAIL wrap k=%0d o=%h busy=%b done=%b idx=%0d expected o=%h busy=%b done=%b idx=%0d",
                         k, o2, busy2, done2, idx2, e.o, e.busy, e.done, e.idx);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_pause();
        exp_t e;
        mode = 1'b1; a = 4'd5; last = 4'd6;
        for (int k = 0; k < 9; k++) begin
            start = (k == 0);
            en    = !(k >= 1 && k <= 3);
            case (k)
                0, 4:    push(16'h0020, 1'b1, 1'b0, 4'd5, 1'b1);
                1, 2, 3: push(16'h0000, 1'b1, 1'b0, 4'd5, 1'b1);
                5, 6:    push(16'h0040, 1'b1, 1'b0, 4'd6, 1'b1);
                7:       push(16'h0000, 1'b0, 1'b1, 4'd6, 1'b1);
                default: push(16'h0000, 1'b0, 1'b0, 4'd6, 1'b1);
            endcase
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (o1 !== e.o || busy1 !== e.busy || done1 !== e.done || (e.chk_idx && idx1 !== e.idx)) begin
                miscompares++;
                $display("FAIL pause k=%0d o=%h busy=%b done=%b idx=%0d expected o=%h busy=%b done=%b idx=%0d",
                         k, o1, busy1, done1, idx1, e.o, e.busy, e.done, e.idx);
            end
        end
        start = 1'b0; en = 1'b1;
    endtask

    // A==Last single position, then Start with Enable low must not begin a scan.
    task automatic test_edge();
        exp_t e;
        mode = 1'b1; a = 4'd9; last = 4'd9;
        for (int k = 0; k < 8; k++) begin
            start = (k == 0) || (k == 4) || (k == 5);
            en    = !(k == 4 || k == 5);
            case (k)
                0, 1:    push(16'h0200, 1'b1, 1'b0, 4'd9, 1'b1);
                2:       push(16'h0000, 1'b0, 1'b1, 4'd9, 1'b1);
                default: push(16'h0000, 1'b0, 1'b0, 4'd9, 1'b1);
            endcase
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (o1 !== e.o || busy1 !== e.busy || done1 !== e.done || (e.chk_idx && idx1 !== e.idx)) begin
                miscompares++;
                $display("FAIL edge k=%0d o=%h busy=%b done=%b idx=%0d expected o=%h busy=%b done=%b idx=%0d",
                         k, o1, busy1, done1, idx1, e.o, e.busy, e.done, e.idx);
            end
        end
        start = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        mode = 1'b1; en = 1'b1; a = 4'd0; last = 4'd15;
        for (int k = 0; k < 3; k++) begin
            start = (k == 0);
            push(16'h0001 << (k / 2), 1'b1, 1'b0, 4'(k / 2), 1'b1);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (o1 !== e.o || busy1 !== e.busy || done1 !== e.done || idx1 !== e.idx) begin
                miscompares++;
                $display("FAIL premid k=%0d o=%h busy=%b idx=%0d expected o=%h busy=%b idx=%0d",
                         k, o1, busy1, idx1, e.o, e.busy, e.idx);
            end
        end
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        push(16'h0000, 1'b0, 1'b0, 4'd0, 1'b1);
        e = exp_q.pop_front();
        vectors++;
        if (o1 !== e.o || busy1 !== e.busy || done1 !== e.done || idx1 !== e.idx) begin
            miscompares++;
            $display("FAIL async_reset o=%h busy=%b done=%b idx=%0d expected all zero", o1, busy1, done1, idx1);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(16'h0000, 1'b0, 1'b0, 4'd0, 1'b1);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (o1 !== e.o || busy1 !== e.busy || done1 !== e.done || idx1 !== e.idx) begin
                miscompares++;
                $display("FAIL post_reset k=%0d o=%h busy=%b done=%b idx=%0d expected all zero",
                         k, o1, busy1, done1, idx1);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_direct();
        test_scan();
        drain(12);
        test_wrap();
        drain(12);
        test_pause();
        drain(12);
        test_edge();
        drain(4);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
